// File: rtl/serial_compare_ctrl_if.sv
// Start/done handshake and operand/result bundle for the serial comparator.
interface serial_compare_ctrl_if #(parameter int SIZE = 8);
  logic            start;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic            busy;
  logic            done;
  logic            EQ;
  logic            LT;
  logic            GT;

  modport master (output start, A, B, input busy, done, EQ, LT, GT);
  modport slave  (input start, A, B, output busy, done, EQ, LT, GT);
endinterface

// File: rtl/serial_compare_ctrl.sv
// Unsigned SIZE-bit magnitude comparator that walks the operands two bits per
// clock, MSB pair first, and stops at the first differing pair.
module serial_compare_ctrl #(
  parameter int SIZE = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_compare_ctrl_if.slave bus
);
  localparam int NP = SIZE / 2;
  localparam int CW = $clog2(NP) + 1;

  if (SIZE < 2 || (SIZE % 2) != 0) begin : g_bad_size
    $error("serial_compare_ctrl: SIZE must be even and >= 2");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t          state, state_nx;
  logic [SIZE-1:0] sh_a, sh_b;
  logic [CW-1:0]   cnt;
  logic [1:0]      pa, pb;
  logic            last, load, step, finish;

  assign pa   = sh_a[SIZE-1 -: 2];
  assign pb   = sh_b[SIZE-1 -: 2];
  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = CMP;
          load     = 1'b1;
        end
      end
      CMP: begin
        // A differing pair decides the result; lower pairs are never looked at.
        if (pa != pb || last) begin
          state_nx = DONE;
          finish   = 1'b1;
        end else begin
          step     = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nx = CMP;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.EQ   <= 1'b0;
      bus.LT   <= 1'b0;
      bus.GT   <= 1'b0;
    end else begin
      // Status flags are decoded from the next state so they line up with it.
      bus.busy <= (state_nx == CMP);
      bus.done <= (state_nx == DONE);
      if (load) begin
        sh_a <= bus.A;
        sh_b <= bus.B;
        cnt  <= CW'(NP);
      end else if (step) begin
        sh_a <= sh_a << 2;
        sh_b <= sh_b << 2;
        cnt  <= cnt - CW'(1);
      end
      if (finish) begin
        bus.EQ <= (pa == pb);
        bus.LT <= (pa <  pb);
        bus.GT <= (pa >  pb);
      end
    end
  end
endmodule
